dsp_mac_ctrl: RTL and testbench
===============================

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of the vector-length field.
REQ-002 Parameter PIPE_LAT, default 3: DSP48A1 operand-to-P latency (A1REG=1, MREG=1, PREG=1).
REQ-003 clk  in  1: single clock, rising edge.
REQ-004 rst_n  in  1: reset, synchronous and active-low.
REQ-005 start  in  1: pulse that begins a dot product; sampled only in IDLE.
REQ-006 len  in  LEN_W: number of A/B pairs; sampled with start.
REQ-007 busy  out  1: high in every state except IDLE.
REQ-008 in_valid / in_ready  in / out  1: operand-stream handshake; a transfer occurs when both are high.
REQ-009 in_a, in_b  in  18: signed operand pair.
REQ-010 dsp_a, dsp_b  out  18: operands to the DSP48A1 A/B ports.
REQ-011 dsp_opmode  out  8: OPMODE to the DSP48A1.
REQ-012 dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ce_opmode  out  1 each: DSP48A1 clock enables.
REQ-013 dsp_rst  out  1: active-high reset to all DSP48A1 RST* pins.
REQ-014 dsp_p  in  48: P output returned from the DSP48A1.
REQ-015 res_valid / res_ready  out / in  1: result handshake.
REQ-016 res_data  out  48: signed dot-product result.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 with len>0 loads remaining=len and goes to RUN; start=1 with len=0 goes directly to DONE with res_data=0.
REQ-019 RUN: in_ready=1 while remaining>0; each transfer (issue cycle t) drives dsp_a=in_a, dsp_b=in_b, dsp_cea=dsp_ceb=1 and decrements remaining.
REQ-020 In RUN and DRAIN, dsp_cea=dsp_ceb=0 in any cycle without a transfer; bubbles never corrupt the accumulation.
REQ-021 A 3-bit valid shift register tracks issued elements: dsp_cem=1 and dsp_ce_opmode=1 at t+1; dsp_cep=1 at t+2.
REQ-022 dsp_opmode is driven at t+1: first element 8'b0000_0001 (X=M, Z=0); each later element 8'b0000_1001 (X=M, Z=P); bits 7:4 are always 0.
REQ-023 The final transfer moves the FSM to DRAIN; DRAIN lasts until the final element's P is registered (t_last+PIPE_LAT).
REQ-024 res_data is captured from dsp_p at t_last+PIPE_LAT; res_valid rises in that cycle and the FSM enters DONE.
REQ-025 DONE: res_valid and res_data stay stable until res_ready=1; the FSM then returns to IDLE and res_valid drops the next cycle.
REQ-026 start is ignored whenever busy=1; in_ready=0 outside RUN.
REQ-027 Arithmetic is 18x18 signed into a 48-bit accumulator; overflow wraps modulo 2^48 and no flag is raised.
REQ-028 All outputs are registered except in_ready, which is decoded from state and remaining.

Reset
REQ-029 While rst_n=0: state=IDLE, remaining=0, valid pipe=0, busy=0, in_ready=0, res_valid=0, res_data=0, dsp_a=dsp_b=0, dsp_opmode=0, all dsp_ce*=0, dsp_rst=1.
REQ-030 dsp_rst is registered ~rst_n; it deasserts one cycle after rst_n rises.
REQ-031 rst_n=0 in any state, including mid-RUN or DRAIN, aborts the operation and discards any partial result.

Structure
REQ-032 A shared package holds the state enum, the two OPMODE constants, and PIPE_LAT.
REQ-033 No sub-module is used; the controller instantiates nothing and drives an externally instantiated DSP48A1.

Verification
REQ-034 The bench pairs this block with a DSP48A1 built using A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODE_Reg=1.
REQ-035 len=3 with pairs (2,3), (4,5), (-1,7) and no gaps -> res_data=19, with res_valid at t_last+3.
REQ-036 Same vectors with in_valid low for 2 cycles between each pair -> res_data=19 and no extra accumulation.
REQ-037 len=1 with pair (-131072,-131072) -> res_data=2^34=0x0004_0000_0000.
REQ-038 res_ready held low 5 cycles after res_valid, with start pulsed meanwhile -> res_data stable, start ignored, IDLE entered only after the handshake.
REQ-039 rst_n=0 for 1 cycle after 2 of 4 transfers, then len=2 with pairs (1,1), (1,1) -> res_data=2 and no residue from the aborted run.
REQ-040 start with len=0 -> res_valid one cycle later with res_data=0, and in_ready never asserts.

Source files
------------

// File: rtl/dsp_mac_ctrl_pkg.sv
// Shared types and DSP48A1 constants for the dot-product MAC controller.
package dsp_mac_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // OPMODE[1:0] selects X, OPMODE[3:2] selects Z; upper nibble stays zero.
  localparam logic [7:0] OPMODE_FIRST = 8'b0000_0001;  // X=M, Z=0
  localparam logic [7:0] OPMODE_ACC   = 8'b0000_1001;  // X=M, Z=P

  localparam int DSP_PIPE_LAT = 3;

endpackage

// File: rtl/dsp_mac_ctrl.sv
// Dot-product controller sequencing operand pairs into an external DSP48A1
// (A1REG/MREG/PREG pipeline) and returning the accumulated 48-bit result.
module dsp_mac_ctrl
  import dsp_mac_ctrl_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = DSP_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      in_a,
  input  logic signed [17:0]      in_b,
  output logic [17:0]             dsp_a,
  output logic [17:0]             dsp_b,
  output logic [7:0]              dsp_opmode,
  output logic                    dsp_cea,
  output logic                    dsp_ceb,
  output logic                    dsp_cem,
  output logic                    dsp_cep,
  output logic                    dsp_ce_opmode,
  output logic                    dsp_rst,
  input  logic [47:0]             dsp_p,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [47:0]             res_data
);

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    remaining_reg, remaining_next;
  logic [PIPE_LAT-1:0] vpipe_reg, vpipe_next;
  logic                first_pending_reg, first_pending_next;
  logic                first_issue_reg, first_issue_next;
  logic [17:0]         dsp_a_reg, dsp_a_next;
  logic [17:0]         dsp_b_reg, dsp_b_next;
  logic [7:0]          opmode_reg, opmode_next;
  logic [47:0]         res_data_reg, res_data_next;
  logic                res_valid_reg, res_valid_next;
  logic                busy_reg, busy_next;
  logic                dsp_rst_reg;
  logic                transfer;

  assign in_ready = (state_reg == ST_RUN) && (remaining_reg != '0);
  assign transfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      remaining_reg     <= '0;
      vpipe_reg         <= '0;
      first_pending_reg <= 1'b0;
      first_issue_reg   <= 1'b0;
      dsp_a_reg         <= '0;
      dsp_b_reg         <= '0;
      opmode_reg        <= '0;
      res_data_reg      <= '0;
      res_valid_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      dsp_rst_reg       <= 1'b1;
    end else begin
      state_reg         <= state_next;
      remaining_reg     <= remaining_next;
      vpipe_reg         <= vpipe_next;
      first_pending_reg <= first_pending_next;
      first_issue_reg   <= first_issue_next;
      dsp_a_reg         <= dsp_a_next;
      dsp_b_reg         <= dsp_b_next;
      opmode_reg        <= opmode_next;
      res_data_reg      <= res_data_next;
      res_valid_reg     <= res_valid_next;
      busy_reg          <= busy_next;
      dsp_rst_reg       <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (transfer && remaining_reg == LEN_W'(1)) state_next = ST_DRAIN;
      // An empty valid pipe means the last element's P is already registered.
      ST_DRAIN: if (vpipe_reg == '0) state_next = ST_DONE;
      ST_DONE:  if (res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    remaining_next     = remaining_reg;
    first_pending_next = first_pending_reg;
    vpipe_next         = {vpipe_reg[PIPE_LAT-2:0], transfer};
    first_issue_next   = transfer && first_pending_reg;
    dsp_a_next         = dsp_a_reg;
    dsp_b_next         = dsp_b_reg;
    opmode_next        = opmode_reg;
    res_data_next      = res_data_reg;
    res_valid_next     = res_valid_reg;
    busy_next          = (state_next != ST_IDLE);

    // The first element must not add the stale P of a previous product.
    if (vpipe_reg[0]) opmode_next = first_issue_reg ? OPMODE_FIRST : OPMODE_ACC;

    if (transfer) begin
      dsp_a_next         = in_a;
      dsp_b_next         = in_b;
      remaining_next     = remaining_reg - LEN_W'(1);
      first_pending_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          remaining_next     = len;
          first_pending_next = 1'b1;
          if (len == '0) begin
            res_data_next  = '0;
            res_valid_next = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (vpipe_reg == '0) begin
          res_data_next  = dsp_p;
          res_valid_next = 1'b1;
        end
      end
      ST_DONE: if (res_ready) res_valid_next = 1'b0;
      default: ;
    endcase
  end

  assign busy          = busy_reg;
  assign dsp_a         = dsp_a_reg;
  assign dsp_b         = dsp_b_reg;
  assign dsp_opmode    = opmode_reg;
  assign dsp_cea       = vpipe_reg[0];
  assign dsp_ceb       = vpipe_reg[0];
  assign dsp_cem       = vpipe_reg[1];
  assign dsp_ce_opmode = vpipe_reg[1];
  assign dsp_cep       = vpipe_reg[PIPE_LAT-1];
  assign dsp_rst       = dsp_rst_reg;
  assign res_valid     = res_valid_reg;
  assign res_data      = res_data_reg;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl: a DSP48A1 stand-in closes the loop, a cycle model
// of the handshake rules checks every output, and directed runs pin results.
module tb_dsp_mac_ctrl;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               busy;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] in_a = '0;
  logic signed [17:0] in_b = '0;
  logic [17:0]        dsp_a, dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ce_opmode, dsp_rst;
  logic [47:0]        dsp_p;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [47:0]        res_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_xfer = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_ce_opmode(dsp_ce_opmode), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // DSP48A1 stand-in: A1REG, B1REG, MREG, OPMODE_Reg, PREG, sync reset.
  logic signed [17:0] a1_q, b1_q;
  logic signed [35:0] m_q;
  logic [7:0]         opm_q;
  logic [47:0]        p_q;
  logic [47:0]        x_mux, z_mux;

  always_comb begin
    x_mux = (opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
    z_mux = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; opm_q <= '0; p_q <= '0;
    end else begin
      if (dsp_cea) a1_q <= dsp_a;
      if (dsp_ceb) b1_q <= dsp_b;
      if (dsp_cem) m_q <= a1_q * b1_q;
      if (dsp_ce_opmode) opm_q <= dsp_opmode;
      if (dsp_cep) p_q <= x_mux + z_mux;
    end
  end
  assign dsp_p = p_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle model: state after each edge, advanced at the negedge before it.
  bit          m_known = 0, m_busy = 0, m_res_valid = 0, m_dsp_rst = 0;
  bit          m_cea = 0, m_cem = 0, m_cep = 0, m_cea_first = 0, m_cem_first = 0;
  int          m_need = 0, m_acc = 0, m_cd = 0;
  longint      m_sum = 0;
  logic [47:0] m_res_data = '0;
  logic [17:0] m_a = '0, m_b = '0;

  always @(negedge clk) begin
    bit xfer;
    if (m_known) begin
      chk("busy", busy, m_busy);
      chk("in_ready", in_ready, m_busy && m_need > 0);
      chk("res_valid", res_valid, m_res_valid);
      chk("res_data", res_data, m_res_data);
      chk("dsp_rst", dsp_rst, m_dsp_rst);
      chk("dsp_cea", dsp_cea, m_cea);
      chk("dsp_ceb", dsp_ceb, m_cea);
      chk("dsp_cem", dsp_cem, m_cem);
      chk("dsp_ce_opmode", dsp_ce_opmode, m_cem);
      chk("dsp_cep", dsp_cep, m_cep);
      chk("opmode_hi", dsp_opmode[7:4], 4'h0);
      if (m_cea) begin
        chk("dsp_a", dsp_a, m_a);
        chk("dsp_b", dsp_b, m_b);
      end
      if (m_cem) chk("dsp_opmode", dsp_opmode, m_cem_first ? 8'h01 : 8'h09);
    end

    xfer = in_valid && m_busy && (m_need > 0);
    if (!rst_n) begin
      m_known = 1; m_busy = 0; m_res_valid = 0; m_res_data = '0; m_dsp_rst = 1;
      m_cea = 0; m_cem = 0; m_cep = 0; m_cea_first = 0; m_cem_first = 0;
      m_need = 0; m_acc = 0; m_cd = 0; m_sum = 0;
    end else begin
      m_dsp_rst   = 0;
      m_cep       = m_cem;
      m_cem       = m_cea;
      m_cem_first = m_cea_first;
      m_cea       = xfer;
      m_cea_first = xfer && (m_acc == 0);
      if (xfer) begin
        m_a = in_a;
        m_b = in_b;
      end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_sum = 0; m_acc = 0; m_need = int'(len);
          if (len == '0) begin
            m_res_valid = 1;
            m_res_data  = '0;
          end
        end
      end else begin
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) begin
            m_res_valid = 1;
            m_res_data  = m_sum[47:0];
          end
        end else if (m_res_valid && res_ready) begin
          m_busy = 0;
          m_res_valid = 0;
        end
        if (xfer) begin
          m_sum = m_sum + longint'(in_a) * longint'(in_b);
          m_acc++;
          m_need--;
          // One edge to issue, then PIPE_LAT edges until P feeds the capture.
          if (m_need == 0) m_cd = PIPE_LAT + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int gap);
    int guard = 0;
    in_valid = 1'b1;
    in_a = 18'(a);
    in_b = 18'(b);
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    step();
    last_xfer = cyc;
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic get_result(input string name, input logic [47:0] exp,
                            input int hold, input bit check_lat);
    int guard = 0;
    while (!res_valid && guard < 50) begin
      step();
      guard++;
    end
    chk({name, "_valid"}, res_valid, 1);
    if (check_lat) chk({name, "_latency"}, 64'(cyc - last_xfer), 64'(PIPE_LAT + 1));
    chk({name, "_data"}, res_data, exp);
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      len   = LEN_W'(1);
      step();
      start = 1'b0;
      chk({name, "_hold_data"}, res_data, exp);
      chk({name, "_hold_valid"}, res_valid, 1);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_drop_valid"}, res_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("reset_dsp_rst", dsp_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_res_data", res_data, 48'd0);
    rst_n = 1'b1;
    chk("dsp_rst_before_edge", dsp_rst, 1);
    step();
    chk("dsp_rst_released", dsp_rst, 0);

    // Back-to-back: 6 + 20 - 7 = 19.
    begin_op(3);
    send(2, 3, 0);
    send(4, 5, 0);
    send(-1, 7, 0);
    get_result("nogap", 48'd19, 0, 1);

    // Same vectors with bubbles between pairs.
    begin_op(3);
    send(2, 3, 2);
    send(4, 5, 2);
    send(-1, 7, 2);
    get_result("gaps", 48'd19, 0, 0);

    // Most-negative operands squared: 2^34.
    begin_op(1);
    send(-131072, -131072, 0);
    get_result("minsq", 48'h0004_0000_0000, 0, 1);

    // Held result with start pulsed while busy: -3000 + 49 = -2951.
    begin_op(2);
    send(1000, -3, 0);
    send(7, 7, 0);
    get_result("hold", 48'hFFFF_FFFF_F479, 5, 0);
    step();
    chk("start_ignored_busy", busy, 0);
    chk("start_ignored_ready", in_ready, 0);

    // Abort after 2 of 4 transfers, then a clean 2-element run.
    begin_op(4);
    send(100, 100, 0);
    send(50, 3, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_res_data", res_data, 48'd0);
    begin_op(2);
    send(1, 1, 0);
    send(1, 1, 0);
    get_result("after_abort", 48'd2, 0, 0);

    // Zero-length vector completes on the next cycle.
    begin_op(0);
    chk("len0_valid_next", res_valid, 1);
    chk("len0_in_ready", in_ready, 0);
    get_result("len0", 48'd0, 0, 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
